// File: rtl/bc_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit basic computer (T0..T6 sequence counter).
// Optional build macro: CTRL_INDIRECT_EN enables the T3 indirect fetch for memory-reference ops.
module bc_control_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ir,
    input  logic             ac_z,
    input  logic             ac_n,
    input  logic             e,
    input  logic             dr_z,
    input  logic             run_req,
    output logic [2:0]       sc,
    output logic [2:0]       bus_sel,
    output logic             ld_ar,
    output logic             inc_ar,
    output logic             ld_pc,
    output logic             inc_pc,
    output logic             ld_ir,
    output logic             ld_dr,
    output logic             inc_dr,
    output logic             ld_ac,
    output logic             clr_ac,
    output logic             inc_ac,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             i_flag,
    output logic [2:0]       alu_opsel,
    output logic [1:0]       e_op,
    output logic             halted
);

    typedef enum logic [2:0] {
        StT0 = 3'd0, StT1 = 3'd1, StT2 = 3'd2, StT3 = 3'd3,
        StT4 = 3'd4, StT5 = 3'd5, StT6 = 3'd6
    } tstate_e;

    localparam logic [2:0] BusAr  = 3'd1;
    localparam logic [2:0] BusPc  = 3'd2;
    localparam logic [2:0] BusDr  = 3'd3;
    localparam logic [2:0] BusAc  = 3'd4;
    localparam logic [2:0] BusIr  = 3'd5;
    localparam logic [2:0] BusMem = 3'd7;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluAnd  = 3'b001;
    localparam logic [2:0] AluPass = 3'b010;
    localparam logic [2:0] AluCma  = 3'b011;
    localparam logic [2:0] AluShr  = 3'b100;
    localparam logic [2:0] AluShl  = 3'b101;
    localparam logic [2:0] AluNop  = 3'b111;

    localparam logic [1:0] EClr  = 2'b01;
    localparam logic [1:0] ECmp  = 2'b10;
    localparam logic [1:0] ELoad = 2'b11;

    localparam logic [2:0] OpAnd = 3'd0;
    localparam logic [2:0] OpAdd = 3'd1;
    localparam logic [2:0] OpLda = 3'd2;
    localparam logic [2:0] OpSta = 3'd3;
    localparam logic [2:0] OpBun = 3'd4;
    localparam logic [2:0] OpBsa = 3'd5;
    localparam logic [2:0] OpIsz = 3'd6;
    localparam logic [2:0] OpReg = 3'd7;

    tstate_e     sc_q, sc_d;
    logic        i_flag_q;
    logic        halted_q;
    logic        hlt_set;
    logic        active;
    logic [2:0]  op;
    logic [11:0] rbits;

    assign op     = ir[14:12];
    assign rbits  = ir[11:0];
    assign active = !rst && !halted_q;
    assign sc     = sc_q;
    assign i_flag = i_flag_q;
    assign halted = halted_q;

    always_comb begin
        case (sc_q)
            StT0:    sc_d = StT1;
            StT1:    sc_d = StT2;
            StT2:    sc_d = StT3;
            StT3:    sc_d = (op == OpReg) ? StT0 : StT4;
            StT4:    sc_d = (op == OpSta || op == OpBun) ? StT0 : StT5;
            StT5:    sc_d = (op == OpIsz) ? StT6 : StT0;
            default: sc_d = StT0;
        endcase
    end

    // Strobes are pure decodes; reset and halt force the whole control word idle.
    always_comb begin
        bus_sel   = 3'd0;
        ld_ar     = 1'b0;
        inc_ar    = 1'b0;
        ld_pc     = 1'b0;
        inc_pc    = 1'b0;
        ld_ir     = 1'b0;
        ld_dr     = 1'b0;
        inc_dr    = 1'b0;
        ld_ac     = 1'b0;
        clr_ac    = 1'b0;
        inc_ac    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        alu_opsel = AluNop;
        e_op      = 2'b00;
        hlt_set   = 1'b0;
        if (active) begin
            case (sc_q)
                StT0: begin
                    bus_sel = BusPc;
                    ld_ar   = 1'b1;
                end
                StT1: begin
                    mem_rd  = 1'b1;
                    bus_sel = BusMem;
                    ld_ir   = 1'b1;
                    inc_pc  = 1'b1;
                end
                StT2: begin
                    bus_sel = BusIr;
                    ld_ar   = 1'b1;
                end
                StT3: begin
                    if (op == OpReg) begin
                        if (!i_flag_q) begin
                            // Highest set address bit selects the single register op.
                            if (rbits[11])     clr_ac = 1'b1;
                            else if (rbits[10]) e_op = EClr;
                            else if (rbits[9]) begin
                                alu_opsel = AluCma;
                                ld_ac     = 1'b1;
                            end
                            else if (rbits[8]) e_op = ECmp;
                            else if (rbits[7]) begin
                                alu_opsel = AluShr;
                                ld_ac     = 1'b1;
                                e_op      = ELoad;
                            end
                            else if (rbits[6]) begin
                                alu_opsel = AluShl;
                                ld_ac     = 1'b1;
                                e_op      = ELoad;
                            end
                            else if (rbits[5]) inc_ac = 1'b1;
                            else if (rbits[4]) inc_pc = !ac_n;
                            else if (rbits[3]) inc_pc = ac_n;
                            else if (rbits[2]) inc_pc = ac_z;
                            else if (rbits[1]) inc_pc = !e;
                            else if (rbits[0]) hlt_set = 1'b1;
                        end
                    end else begin
`ifdef CTRL_INDIRECT_EN
                        if (i_flag_q) begin
                            mem_rd  = 1'b1;
                            bus_sel = BusMem;
                            ld_ar   = 1'b1;
                        end
`endif
                    end
                end
                StT4: begin
                    case (op)
                        OpAnd, OpAdd, OpLda, OpIsz: begin
                            mem_rd  = 1'b1;
                            bus_sel = BusMem;
                            ld_dr   = 1'b1;
                        end
                        OpSta: begin
                            bus_sel = BusAc;
                            mem_wr  = 1'b1;
                        end
                        OpBun: begin
                            bus_sel = BusAr;
                            ld_pc   = 1'b1;
                        end
                        OpBsa: begin
                            bus_sel = BusPc;
                            mem_wr  = 1'b1;
                            inc_ar  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StT5: begin
                    case (op)
                        OpAnd: begin
                            alu_opsel = AluAnd;
                            ld_ac     = 1'b1;
                        end
                        OpAdd: begin
                            alu_opsel = AluAdd;
                            ld_ac     = 1'b1;
                            e_op      = ELoad;
                        end
                        OpLda: begin
                            alu_opsel = AluPass;
                            ld_ac     = 1'b1;
                        end
                        OpBsa: begin
                            bus_sel = BusAr;
                            ld_pc   = 1'b1;
                        end
                        OpIsz:   inc_dr = 1'b1;
                        default: ;
                    endcase
                end
                StT6: begin
                    bus_sel = BusDr;
                    mem_wr  = 1'b1;
                    inc_pc  = dr_z;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q     <= StT0;
            i_flag_q <= 1'b0;
            halted_q <= 1'b0;
        end else if (halted_q) begin
            sc_q <= StT0;
            if (run_req) halted_q <= 1'b0;
        end else begin
            sc_q <= sc_d;
            if (sc_q == StT2) i_flag_q <= ir[15];
            if (hlt_set) halted_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bc_control_unit.sv
// Scoreboard bench for bc_control_unit: an instruction-level model queues the expected control
// word per cycle, and a negedge monitor pops and compares it against the DUT outputs.
module tb_bc_control_unit;

    typedef struct packed {
        logic [2:0] sc;
        logic [2:0] bus;
        logic       ld_ar, inc_ar, ld_pc, inc_pc, ld_ir, ld_dr, inc_dr;
        logic       ld_ac, clr_ac, inc_ac, rd, wr, iflag;
        logic [2:0] op;
        logic [1:0] eop;
        logic       halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, ac_z, ac_n, e, dr_z, run_req;
    logic [15:0] ir;
    logic [2:0]  sc, bus_sel, alu_opsel;
    logic [1:0]  e_op;
    logic        ld_ar, inc_ar, ld_pc, inc_pc, ld_ir, ld_dr, inc_dr, ld_ac, clr_ac, inc_ac;
    logic        mem_rd, mem_wr, i_flag, halted;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  m_iflag = 1'b0;
    logic  m_halted = 1'b0;

    bc_control_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ir(ir), .ac_z(ac_z), .ac_n(ac_n), .e(e), .dr_z(dr_z),
        .run_req(run_req), .sc(sc), .bus_sel(bus_sel), .ld_ar(ld_ar), .inc_ar(inc_ar),
        .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_ir(ld_ir), .ld_dr(ld_dr), .inc_dr(inc_dr),
        .ld_ac(ld_ac), .clr_ac(clr_ac), .inc_ac(inc_ac), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .i_flag(i_flag), .alu_opsel(alu_opsel), .e_op(e_op), .halted(halted)
    );

    always #5 clk = !clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  x, a;
            string t;
            x = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{sc, bus_sel, ld_ar, inc_ar, ld_pc, inc_pc, ld_ir, ld_dr, inc_dr,
                  ld_ac, clr_ac, inc_ac, mem_rd, mem_wr, i_flag, alu_opsel, e_op, halted};
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL %s: got=%h expected=%h", t, a, x);
            end
        end
    end

    function automatic exp_t idle(input int t, input logic f, input logic h);
        exp_t x;
        x        = '0;
        x.sc     = t[2:0];
        x.iflag  = f;
        x.op     = 3'b111;
        x.halted = h;
        return x;
    endfunction

    task automatic step(input exp_t x, input string tag);
        exp_q.push_back(x);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input int fdz, input int fan);
        ac_z    = 1'($urandom);
        ac_n    = (fan < 0) ? 1'($urandom) : fan[0];
        e       = 1'($urandom);
        dr_z    = (fdz < 0) ? 1'($urandom) : fdz[0];
        run_req = 1'($urandom);
    endtask

    // One instruction from T0; abort_at >= 0 asserts rst for two cycles at that T-step.
    task automatic run_instr(input logic [15:0] w, input int fdz, input int fan, input int abort_at);
        logic [2:0] op;
        int         len;
        int         hb;
        exp_t       x;
        op  = w[14:12];
        len = (op == 3'd7) ? 4 : (op == 3'd3 || op == 3'd4) ? 5 : (op == 3'd6) ? 7 : 6;
        for (int t = 0; t < len; t++) begin
            ir = w;
            rand_inputs(fdz, fan);
            if (t == 3) m_iflag = w[15];
            if (t == abort_at) begin
                rst = 1'b1;
                step(idle(t, m_iflag, 1'b0), $sformatf("rst1 ir=%h", w));
                m_iflag = 1'b0;
                step(idle(0, 1'b0, 1'b0), $sformatf("rst2 ir=%h", w));
                rst = 1'b0;
                return;
            end
            x = idle(t, m_iflag, 1'b0);
            case (t)
                0: begin x.bus = 3'd2; x.ld_ar = 1; end
                1: begin x.rd = 1; x.bus = 3'd7; x.ld_ir = 1; x.inc_pc = 1; end
                2: begin x.bus = 3'd5; x.ld_ar = 1; end
                3: begin
                    if (op == 3'd7 && !w[15]) begin
                        hb = -1;
                        for (int i = 11; i >= 0; i--) if (w[i] && hb < 0) hb = i;
                        case (hb)
                            11: x.clr_ac = 1;
                            10: x.eop = 2'b01;
                            9:  begin x.op = 3'b011; x.ld_ac = 1; end
                            8:  x.eop = 2'b10;
                            7:  begin x.op = 3'b100; x.ld_ac = 1; x.eop = 2'b11; end
                            6:  begin x.op = 3'b101; x.ld_ac = 1; x.eop = 2'b11; end
                            5:  x.inc_ac = 1;
                            4:  x.inc_pc = !ac_n;
                            3:  x.inc_pc = ac_n;
                            2:  x.inc_pc = ac_z;
                            1:  x.inc_pc = !e;
                            0:  m_halted = 1'b1;
                            default: ;
                        endcase
                    end
`ifdef CTRL_INDIRECT_EN
                    else if (op != 3'd7 && w[15]) begin
                        x.rd = 1; x.bus = 3'd7; x.ld_ar = 1;
                    end
`endif
                end
                4: case (op)
                    3'd3: begin x.bus = 3'd4; x.wr = 1; end
                    3'd4: begin x.bus = 3'd1; x.ld_pc = 1; end
                    3'd5: begin x.bus = 3'd2; x.wr = 1; x.inc_ar = 1; end
                    default: begin x.rd = 1; x.bus = 3'd7; x.ld_dr = 1; end
                endcase
                5: case (op)
                    3'd0: begin x.op = 3'b001; x.ld_ac = 1; end
                    3'd1: begin x.op = 3'b000; x.ld_ac = 1; x.eop = 2'b11; end
                    3'd2: begin x.op = 3'b010; x.ld_ac = 1; end
                    3'd5: begin x.bus = 3'd1; x.ld_pc = 1; end
                    default: x.inc_dr = 1;
                endcase
                default: begin x.bus = 3'd3; x.wr = 1; x.inc_pc = dr_z; end
            endcase
            step(x, $sformatf("ir=%h T%0d", w, t));
        end
    endtask

    task automatic run_halted(input int n);
        for (int i = 0; i < n; i++) begin
            rand_inputs(-1, -1);
            ir      = 16'($urandom);
            run_req = 1'b0;
            step(idle(0, m_iflag, 1'b1), "halted");
        end
        run_req = 1'b1;
        step(idle(0, m_iflag, 1'b1), "run_req");
        run_req  = 1'b0;
        m_halted = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1; ir = '0; ac_z = 0; ac_n = 0; e = 0; dr_z = 0; run_req = 0;
        repeat (2) @(posedge clk);
        #1;
        step(idle(0, 1'b0, 1'b0), "reset");
        rst = 1'b0;

        run_instr(16'h6050, -1, -1, 5);
        run_instr(16'h1123, -1, -1, -1);
        run_instr(16'h6050, 1, -1, -1);
        run_instr(16'h6050, 0, -1, -1);
        run_instr(16'h7880, -1, -1, -1);
        run_instr(16'h7010, -1, 0, -1);
        run_instr(16'h7001, -1, -1, -1);
        if (m_halted) run_halted(10);
        run_instr(16'hA200, -1, -1, -1);
        run_instr(16'hF040, -1, -1, -1);
        run_instr(16'h5123, -1, -1, -1);

        for (int n = 0; n < 200; n++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[14:12] = 3'd7;
            if ($urandom_range(0, 30) == 0) w = 16'h7001;
            run_instr(w, -1, -1, ($urandom_range(0, 40) == 0) ? int'($urandom_range(0, 3)) : -1);
            if (m_halted) run_halted(int'($urandom_range(1, 4)));
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
